led7seg_display: RTL and testbench

Multi-digit 7-segment display controller and the parametrised successor to the single-digit hex decoder. It latches a packed value on a `load` strobe and shows it on `DIGITS` segment groups in hexadecimal or decimal. Decimal mode uses a multi-cycle binary-to-BCD converter with a busy handshake. The block also provides leading-zero blanking, per-digit blinking, overflow indication and an optional active-low output. It sits between lab datapaths (counters, ALU results) and the board's static 7-segment banks.

---
 rtl/led7seg_display.sv | 175 +++++++++++++++++
 tb/tb_led7seg_display.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led7seg_display.sv
// Multi-digit 7-segment controller: hex/decimal display with a double-dabble
// converter, leading-zero blanking, per-digit blink, overflow dash and optional inversion.
module led7seg_display #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned BLINK_DIV  = 24,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  mode,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  en,
  output logic                  busy,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned SW = 7 * DIGITS;
  localparam int unsigned CW = $clog2(W);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < int'(n); k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  typedef enum logic {IDLE, CONV} state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 dash_q, dash_d;
  logic [W-1:0]         digits_q, digits_d;
  logic [W-1:0]         shift_q, shift_d;
  logic [W-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BLINK_DIV-1:0] blink_q, blink_d;

  logic [W-1:0]         bcd_adj;
  logic [W-1:0]         bcd_shift;
  logic [SW-1:0]        seg_raw;
  logic [3:0]           nib;
  logic [6:0]           g_sel;
  logic                 zero_run;

  // Next-state: load handling, one double-dabble step per CONV cycle.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    dash_d   = dash_q;
    digits_d = digits_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    blink_d  = blink_q + BLINK_DIV'(1);
    bcd_adj  = bcd_q;

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[W-2:0], shift_q[W-1]};

    unique case (state_q)
      IDLE: begin
        if (load) begin
          if (!mode) begin
            digits_d = value;
            dash_d   = 1'b0;
            ovf_d    = 1'b0;
          end else if (64'(value) >= LIMIT) begin
            dash_d   = 1'b1;
            ovf_d    = 1'b1;
          end else begin
            shift_d  = value;
            bcd_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = CONV;
          end
        end
      end
      CONV: begin
        bcd_d   = bcd_shift;
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          digits_d = bcd_shift;
          dash_d   = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dash_q   <= 1'b0;
      digits_q <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      dash_q   <= dash_d;
      digits_q <= digits_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      blink_q  <= blink_d;
    end
  end

  // Per-digit priority; scan from the top so zero_run covers D[i..DIGITS-1].
  always_comb begin
    seg_raw  = '0;
    nib      = '0;
    g_sel    = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib      = digits_q[4*i +: 4];
      zero_run = zero_run & (nib == 4'd0);
      if (!en)                                  g_sel = 7'h00;
      else if (blink_q[BLINK_DIV-1] && blink_mask[i]) g_sel = 7'h00;
      else if (dash_q)                          g_sel = 7'h40;
      else if (lz_blank && (i > 0) && zero_run) g_sel = 7'h00;
      else                                      g_sel = glyph(nib);
      seg_raw[7*i +: 7] = g_sel;
    end
  end

  assign seg      = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led7seg_display.sv
// Scoreboard bench for led7seg_display: cycle-tagged display checks plus
// decimal results checked when busy falls.
module tb_led7seg_display;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 16;
  localparam int unsigned SW     = 28;

  logic clk = 1'b0;
  logic rst, load, mode, lz_blank, en;
  logic [W-1:0]      value;
  logic [DIGITS-1:0] blink_mask;
  logic busy, overflow, busy_n, overflow_n;
  logic [SW-1:0] seg, seg_n;

  always #5 clk = ~clk;

  led7seg_display #(.DIGITS(DIGITS), .BLINK_DIV(3), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .mode(mode),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .en(en),
    .busy(busy), .overflow(overflow), .seg(seg));

  led7seg_display #(.DIGITS(DIGITS), .BLINK_DIV(3), .ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst(rst), .load(load), .value(value), .mode(mode),
    .lz_blank(lz_blank), .blink_mask(blink_mask), .en(en),
    .busy(busy_n), .overflow(overflow_n), .seg(seg_n));

  typedef struct {
    int            cyc;
    int            id;
    bit            inv;
    logic [SW-1:0] seg;
    logic          busy;
    logic          ovf;
  } chk_t;

  typedef struct {
    int            id;
    logic [SW-1:0] seg;
    int            len;
  } dec_t;

  chk_t chk_q[$];
  dec_t dec_q[$];
  chk_t mon_c;
  dec_t mon_d;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_len = 0;
  logic busy_prev = 1'b0;
  bit   final_chk = 1'b0;
  bit   final_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SW-1:0] pk(input logic [7:0] d3, input logic [7:0] d2,
                                       input logic [7:0] d1, input logic [7:0] d0);
    return {d3[6:0], d2[6:0], d1[6:0], d0[6:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int when, input int id, input bit inv,
                           input logic [SW-1:0] s, input logic b, input logic o);
    chk_t c;
    c.cyc = when; c.id = id; c.inv = inv; c.seg = s; c.busy = b; c.ovf = o;
    chk_q.push_back(c);
  endtask

  task automatic expect_dec(input int id, input logic [SW-1:0] s, input int len);
    dec_t d;
    d.id = id; d.seg = s; d.len = len;
    dec_q.push_back(d);
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick;
      k++;
    end
    if (busy) begin
      $display("FAIL wait_idle: busy=%b after 40 cycles, want 0", busy);
      $fatal(1, "conversion never finished");
    end
  endtask

  // Monitor: tagged display checks and decimal results popped on busy fall.
  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      mon_c = chk_q.pop_front();
      n_checks++;
      if (mon_c.cyc != cyc) begin
        n_fail++;
        $display("FAIL chk%0d: checked at cycle %0d, want cycle %0d", mon_c.id, cyc, mon_c.cyc);
      end else if (mon_c.inv) begin
        if (seg_n !== mon_c.seg) begin
          n_fail++;
          $display("FAIL chk%0d active_low seg: got %h want %h", mon_c.id, seg_n, mon_c.seg);
        end
      end else if (seg !== mon_c.seg || busy !== mon_c.busy || overflow !== mon_c.ovf) begin
        n_fail++;
        $display("FAIL chk%0d: seg/busy/ovf got %h/%b/%b want %h/%b/%b", mon_c.id,
                 seg, busy, overflow, mon_c.seg, mon_c.busy, mon_c.ovf);
      end
    end
    if (busy) begin
      busy_len++;
    end else if (busy_prev) begin
      n_checks++;
      if (dec_q.size() == 0) begin
        n_fail++;
        $display("FAIL busy_fall: unexpected conversion of %0d cycles, want none", busy_len);
      end else begin
        mon_d = dec_q.pop_front();
        if (seg !== mon_d.seg || busy_len != mon_d.len) begin
          n_fail++;
          $display("FAIL dec%0d: seg/busy_len got %h/%0d want %h/%0d", mon_d.id,
                   seg, busy_len, mon_d.seg, mon_d.len);
        end
      end
      busy_len = 0;
    end
    busy_prev = busy;
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      n_checks++;
      if (chk_q.size() + dec_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations left, want 0", chk_q.size() + dec_q.size());
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1; load = 1'b0; mode = 1'b0; value = '0;
    lz_blank = 1'b0; en = 1'b1; blink_mask = '0;
    tick; tick;
    rst = 1'b0;
    expect_at(cyc, 1, 1'b0, pk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 1'b0, 1'b0);
    expect_at(cyc, 2, 1'b1, pk(8'h40, 8'h40, 8'h40, 8'h40), 1'b0, 1'b0);
    tick;

    // Hex load, latency 1.
    value = 16'hA1F0; mode = 1'b0; load = 1'b1;
    expect_at(cyc + 1, 3, 1'b0, pk(8'h77, 8'h06, 8'h71, 8'h3F), 1'b0, 1'b0);
    tick; load = 1'b0; tick;

    // Decimal 1234, old display held during conversion.
    value = 16'd1234; mode = 1'b1; load = 1'b1;
    expect_dec(4, pk(8'h06, 8'h5B, 8'h4F, 8'h66), 16);
    expect_at(cyc + 1, 5, 1'b0, pk(8'h77, 8'h06, 8'h71, 8'h3F), 1'b1, 1'b0);
    expect_at(cyc + 9, 6, 1'b0, pk(8'h77, 8'h06, 8'h71, 8'h3F), 1'b1, 1'b0);
    tick; load = 1'b0;
    wait_idle;
    expect_at(cyc, 7, 1'b0, pk(8'h06, 8'h5B, 8'h4F, 8'h66), 1'b0, 1'b0);
    tick;

    // Decimal 7 with leading-zero blanking.
    lz_blank = 1'b1;
    value = 16'd7; mode = 1'b1; load = 1'b1;
    expect_dec(8, pk(8'h00, 8'h00, 8'h00, 8'h07), 16);
    tick; load = 1'b0;
    wait_idle;
    tick;
    lz_blank = 1'b0;
    expect_at(cyc, 9, 1'b0, pk(8'h3F, 8'h3F, 8'h3F, 8'h07), 1'b0, 1'b0);
    tick;

    // Decimal overflow, then hex load clears it.
    value = 16'd10000; mode = 1'b1; load = 1'b1;
    expect_at(cyc + 1, 10, 1'b0, pk(8'h40, 8'h40, 8'h40, 8'h40), 1'b0, 1'b1);
    expect_at(cyc + 1, 11, 1'b1, pk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 1'b0, 1'b1);
    tick; load = 1'b0; tick;
    value = 16'h0042; mode = 1'b0; load = 1'b1;
    expect_at(cyc + 1, 12, 1'b0, pk(8'h3F, 8'h3F, 8'h66, 8'h5B), 1'b0, 1'b0);
    tick; load = 1'b0; tick;
    lz_blank = 1'b1;
    expect_at(cyc, 13, 1'b0, pk(8'h00, 8'h00, 8'h66, 8'h5B), 1'b0, 1'b0);
    tick; lz_blank = 1'b0; tick;

    // Load during conversion is dropped; next load accepted on first idle cycle.
    value = 16'd9876; mode = 1'b1; load = 1'b1;
    expect_dec(14, pk(8'h6F, 8'h7F, 8'h07, 8'h7D), 16);
    tick; load = 1'b0;
    tick; tick; tick;
    value = 16'd5; load = 1'b1;
    tick; load = 1'b0;
    wait_idle;
    expect_at(cyc, 16, 1'b0, pk(8'h6F, 8'h7F, 8'h07, 8'h7D), 1'b0, 1'b0);
    value = 16'd42; mode = 1'b1; load = 1'b1;
    expect_dec(15, pk(8'h3F, 8'h3F, 8'h66, 8'h5B), 16);
    tick; load = 1'b0;
    wait_idle;
    tick;

    // Reset mid-conversion aborts after 5 busy cycles.
    value = 16'd1111; mode = 1'b1; load = 1'b1;
    expect_dec(17, pk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 5);
    tick; load = 1'b0;
    tick; tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    r = cyc;
    expect_at(r, 18, 1'b0, pk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 1'b0, 1'b0);

    // Blink on digit 0: 4 cycles shown, 4 blank, starting from reset.
    blink_mask = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      expect_at(r + k, 19 + k, 1'b0,
                pk(8'h3F, 8'h3F, 8'h3F, ((k % 8) >= 4) ? 8'h00 : 8'h3F), 1'b0, 1'b0);
    end
    for (int k = 0; k < 16; k++) tick;
    blink_mask = '0;

    // Enable low blanks everything, both polarities.
    en = 1'b0;
    expect_at(cyc, 40, 1'b0, pk(8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0);
    expect_at(cyc, 41, 1'b1, pk(8'h7F, 8'h7F, 8'h7F, 8'h7F), 1'b0, 1'b0);
    tick; en = 1'b1; tick;

    // Reset wins over a simultaneous load.
    value = 16'h5678; mode = 1'b0; load = 1'b1;
    expect_at(cyc + 1, 42, 1'b0, pk(8'h6D, 8'h7D, 8'h07, 8'h7F), 1'b0, 1'b0);
    tick; load = 1'b0; tick;
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    tick;
    rst = 1'b0; load = 1'b0;
    expect_at(cyc, 43, 1'b0, pk(8'h3F, 8'h3F, 8'h3F, 8'h3F), 1'b0, 1'b0);
    tick;

    for (int k = 0; k < 50 && (chk_q.size() > 0 || dec_q.size() > 0); k++) tick;
    final_chk = 1'b1;
    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
